xsnd_tone: RTL

- Memory-mapped square-wave tone generator for picoversat.
- Consumes the sound-region select produced by the address decoder; the CPU writes note descriptors into a small queue.
- The block plays queued notes back-to-back on a single speaker output.
- Read data is returned combinationally to the decoder's read mux.

---
 rtl/xsnd_tone.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/xsnd_tone.sv
// xsnd_tone: memory-mapped square-wave tone generator for picoversat.
// Note descriptors {dur, half} are queued by the CPU and played back-to-back on spk.
module xsnd_tone #(
  parameter int FIFO_DEPTH = 4,
  parameter int TICK_DIV   = 1000,
  parameter int SND_ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sel,
  input  logic                  we,
  input  logic [SND_ADDR_W-1:0] addr,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  spk,
  output logic                  busy
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [SND_ADDR_W-1:0] A_NOTE   = SND_ADDR_W'(32'd0);
  localparam logic [SND_ADDR_W-1:0] A_CTRL   = SND_ADDR_W'(32'd1);
  localparam logic [SND_ADDR_W-1:0] A_STATUS = SND_ADDR_W'(32'd2);
  localparam logic [SND_ADDR_W-1:0] A_DONE   = SND_ADDR_W'(32'd3);
  localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PRE_W-1:0]      PRE_MAX  = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  state_t           state_r, fsm_nxt_s, state_nxt_s;
  logic [31:0]      mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic [15:0]      half_r, half_cnt_r, dur_cnt_r;
  logic [15:0]      half_nxt_s, half_cnt_nxt_s, dur_nxt_s;
  logic [PRE_W-1:0] presc_r, presc_nxt_s;
  logic [31:0]      done_r, done_nxt_s, head_s;
  logic [3:0]       cnt4_s;
  logic             enable_r, overflow_r, phase_r, spk_r, busy_r;
  logic             en_nxt_s, ovf_nxt_s, phase_nxt_s, spk_nxt_s, busy_nxt_s;
  logic             push_s, push_ok_s, pop_s, ctrl_wr_s, flush_s, clr_ovf_s;
  logic             empty_s, full_s, note_done_s;

  // Bus write decode and queue status flags.
  always_comb begin
    push_s    = sel & we & (addr == A_NOTE);
    ctrl_wr_s = sel & we & (addr == A_CTRL);
    flush_s   = ctrl_wr_s & data_in[1];
    clr_ovf_s = ctrl_wr_s & data_in[2];
    if (ctrl_wr_s) begin
      en_nxt_s = data_in[0];
    end else begin
      en_nxt_s = enable_r;
    end
    empty_s = (count_r == {CNT_W{1'b0}});
    full_s  = (count_r == DEPTH_C);
    head_s  = mem_r[rd_ptr_r];
    cnt4_s  = 4'(count_r);
  end

  // Playback sequencer: next state and note counters.
  always_comb begin
    fsm_nxt_s      = state_r;
    pop_s          = 1'b0;
    note_done_s    = 1'b0;
    half_nxt_s     = half_r;
    half_cnt_nxt_s = half_cnt_r;
    dur_nxt_s      = dur_cnt_r;
    presc_nxt_s    = presc_r;
    phase_nxt_s    = phase_r;
    case (state_r)
      ST_IDLE: begin
        phase_nxt_s = 1'b0;
        if (enable_r && !empty_s) begin
          fsm_nxt_s = ST_LOAD;
        end else begin
          fsm_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        pop_s          = ~empty_s;
        half_nxt_s     = head_s[15:0];
        half_cnt_nxt_s = head_s[15:0];
        dur_nxt_s      = head_s[31:16];
        presc_nxt_s    = {PRE_W{1'b0}};
        phase_nxt_s    = 1'b0;
        if (empty_s || (head_s[31:16] == 16'd0)) begin
          fsm_nxt_s = ST_IDLE;
        end else begin
          fsm_nxt_s = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (enable_r) begin
          // A zero half period is a rest: the phase never toggles.
          if (half_r == 16'd0) begin
            phase_nxt_s = 1'b0;
          end else if (half_cnt_r == 16'd1) begin
            half_cnt_nxt_s = half_r;
            phase_nxt_s    = ~phase_r;
          end else begin
            half_cnt_nxt_s = half_cnt_r - 16'd1;
          end
          if (presc_r == PRE_MAX) begin
            presc_nxt_s = {PRE_W{1'b0}};
            dur_nxt_s   = dur_cnt_r - 16'd1;
            if (dur_cnt_r == 16'd1) begin
              fsm_nxt_s   = ST_IDLE;
              phase_nxt_s = 1'b0;
              note_done_s = 1'b1;
            end else begin
              fsm_nxt_s = ST_PLAY;
            end
          end else begin
            presc_nxt_s = presc_r + PRE_W'(1'b1);
          end
        end else begin
          fsm_nxt_s = ST_PLAY;
        end
      end
      default: begin
        fsm_nxt_s = ST_IDLE;
      end
    endcase
    state_nxt_s = flush_s ? ST_IDLE : fsm_nxt_s;
    done_nxt_s  = (note_done_s & ~flush_s) ? (done_r + 32'd1) : done_r;
    // spk is registered, so it looks ahead at the enable and state of the next cycle.
    spk_nxt_s   = (state_nxt_s == ST_PLAY) & en_nxt_s & phase_nxt_s;
    busy_nxt_s  = (state_nxt_s != ST_IDLE);
  end

  // Note queue pointers, occupancy and sticky overflow; flush overrides a pop.
  always_comb begin
    push_ok_s    = push_s & (~full_s | pop_s);
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (flush_s) begin
      wr_ptr_nxt_s = {PTR_W{1'b0}};
      rd_ptr_nxt_s = {PTR_W{1'b0}};
      count_nxt_s  = {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1'b1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1'b1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      count_nxt_s = count_r + CNT_W'(push_ok_s) - CNT_W'(pop_s);
    end
    if (clr_ovf_s) begin
      ovf_nxt_s = 1'b0;
    end else if (push_s && !push_ok_s) begin
      ovf_nxt_s = 1'b1;
    end else begin
      ovf_nxt_s = overflow_r;
    end
  end

  // Note storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      half_r     <= 16'd0;
      half_cnt_r <= 16'd0;
      dur_cnt_r  <= 16'd0;
      presc_r    <= {PRE_W{1'b0}};
      done_r     <= 32'd0;
      enable_r   <= 1'b0;
      overflow_r <= 1'b0;
      phase_r    <= 1'b0;
      spk_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      half_r     <= half_nxt_s;
      half_cnt_r <= half_cnt_nxt_s;
      dur_cnt_r  <= dur_nxt_s;
      presc_r    <= presc_nxt_s;
      done_r     <= done_nxt_s;
      enable_r   <= en_nxt_s;
      overflow_r <= ovf_nxt_s;
      phase_r    <= phase_nxt_s;
      spk_r      <= spk_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  // Combinational read mux toward the decoder.
  always_comb begin
    data_out = 32'd0;
    if (sel && !we) begin
      case (addr)
        A_CTRL:   data_out = {31'd0, enable_r};
        A_STATUS: data_out = {24'd0, cnt4_s, overflow_r, busy_r, full_s, empty_s};
        A_DONE:   data_out = done_r;
        default:  data_out = 32'd0;
      endcase
    end else begin
      data_out = 32'd0;
    end
  end

  assign spk  = spk_r;
  assign busy = busy_r;
endmodule
